nn_infer_ctrl: RTL and testbench

Sequencer for the MNIST two-layer fully-connected network. On a Start pulse (the debounced Compute key), it walks the 28x28 1-bit canvas and the weight ROM, drives a single signed MAC through both layers, and stores ReLU-quantised hidden activations in a local buffer. It then arg-maxes the 10 output logits and presents the winning digit to the HEX/VGA display logic.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_hidden_buf.sv | 27 ++
 rtl/nn_infer_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_nn_infer_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: default network dimensions, derived ROM geometry and FSM state type
// shared by the nn_infer_ctrl sequencer and its hidden-activation buffer.
package nn_pkg;

    localparam int unsigned DEF_N_IN  = 784;
    localparam int unsigned DEF_N_HID = 32;
    localparam int unsigned DEF_N_OUT = 10;
    localparam int unsigned DEF_W_W   = 8;
    localparam int unsigned DEF_ACC_W = 24;
    localparam int unsigned DEF_SHIFT = 6;

    // Layer-2 neurons start right after all layer-1 weight/bias rows.
    localparam int unsigned L2_BASE   = DEF_N_HID * (DEF_N_IN + 1);
    localparam int unsigned ROM_DEPTH = L2_BASE + DEF_N_OUT * (DEF_N_HID + 1);
    localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        L1,
        L2,
        FIN
    } nn_state_t;

endpackage

// File: rtl/nn_hidden_buf.sv
// nn_hidden_buf: N_HID x 8 hidden-activation RAM, one write port and one
// registered read port (1-cycle read latency). Contents are not reset.
module nn_hidden_buf
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_N_HID,
    parameter int unsigned AW    = $clog2(DEF_N_HID)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Synchronous write and registered read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: two-layer MNIST MLP sequencer. Walks canvas and weight ROM,
// drives one signed MAC through both layers, stores ReLU-quantised hidden
// activations and arg-maxes the output logits into Digit.
// Optional feature macro NN_SCORE_OUT_EN adds the Max_score output port.
module nn_infer_ctrl
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_HID = DEF_N_HID,
    parameter int unsigned N_OUT = DEF_N_OUT,
    parameter int unsigned W_W   = DEF_W_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned SHIFT = DEF_SHIFT,
    localparam int unsigned WA_W = $clog2(N_HID * (N_IN + 1) + N_OUT * (N_HID + 1))
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic [3:0]              Digit,
    output logic [9:0]              Pix_addr,
    input  logic                    Pix_data,
    output logic [WA_W-1:0]         W_addr,
`ifdef NN_SCORE_OUT_EN
    output logic signed [ACC_W-1:0] Max_score,
`endif
    input  logic signed [W_W-1:0]   W_data
);

    localparam int unsigned L2_OFS  = N_HID * (N_IN + 1);
    localparam int unsigned IDX_MAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int unsigned IW      = $clog2(IDX_MAX + 2);
    localparam int unsigned NRN_MAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int unsigned NW      = $clog2(NRN_MAX);
    localparam int unsigned HW      = $clog2(N_HID);

    localparam logic [IW-1:0] L1_BIAS  = IW'(N_IN);
    localparam logic [IW-1:0] L1_DRAIN = IW'(N_IN + 1);
    localparam logic [IW-1:0] L2_BIAS  = IW'(N_HID);
    localparam logic [IW-1:0] L2_DRAIN = IW'(N_HID + 1);
    localparam logic [NW-1:0] L1_LAST  = NW'(N_HID - 1);
    localparam logic [NW-1:0] L2_LAST  = NW'(N_OUT - 1);

    nn_state_t               state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NW-1:0]           nrn_q, nrn_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic [3:0]              cand_q, cand_d;
    logic [3:0]              digit_q, digit_d;
`ifdef NN_SCORE_OUT_EN
    logic signed [ACC_W-1:0] score_q, score_d;
`endif

    logic signed [ACC_W-1:0] w_ext, l1_term, l2_term, sum_bias, acc_sh;
    logic signed [W_W+8:0]   hid_s, wd_s, prod;
    logic [7:0]              hid_rd, hid_wr;
    logic                    win_upd;
    logic                    buf_we;
    logic [HW-1:0]           buf_waddr, buf_raddr;

    nn_hidden_buf #(
        .DEPTH (N_HID),
        .AW    (HW)
    ) u_hid_buf (
        .clk_i   (Clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (hid_wr),
        .raddr_i (buf_raddr),
        .rdata_o (hid_rd)
    );

    // MAC operands, bias-completed sum, ReLU/clamp quantiser and argmax compare.
    always_comb begin
        w_ext    = {{(ACC_W - W_W){W_data[W_W-1]}}, W_data};
        l1_term  = Pix_data ? w_ext : '0;
        hid_s    = {{W_W{1'b0}}, hid_rd};
        wd_s     = {{9{W_data[W_W-1]}}, W_data};
        prod     = hid_s * wd_s;
        l2_term  = {{(ACC_W - W_W - 9){prod[W_W+8]}}, prod};
        sum_bias = acc_q + w_ext;
        acc_sh   = sum_bias >>> SHIFT;
        if (acc_sh[ACC_W-1]) begin
            hid_wr = '0;
        end else if (|acc_sh[ACC_W-2:8]) begin
            hid_wr = '1;
        end else begin
            hid_wr = acc_sh[7:0];
        end
        win_upd = (nrn_q == '0) || (sum_bias > best_q);
    end

    // Next-state, counters, accumulator and output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nrn_d     = nrn_q;
        acc_d     = acc_q;
        best_d    = best_q;
        cand_d    = cand_q;
        digit_d   = digit_q;
`ifdef NN_SCORE_OUT_EN
        score_d   = score_q;
`endif
        buf_we    = 1'b0;
        buf_waddr = HW'(nrn_q);
        buf_raddr = '0;
        W_addr    = '0;
        Pix_addr  = '0;
        Busy      = 1'b0;
        Done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = L1;
                    idx_d   = '0;
                    nrn_d   = '0;
                end
            end

            // Data arriving in cycle idx belongs to the address of idx-1;
            // the cycle after the bias address is the drain.
            L1: begin
                Busy = 1'b1;
                if (idx_q <= L1_BIAS) begin
                    W_addr = WA_W'(nrn_q) * WA_W'(N_IN + 1) + WA_W'(idx_q);
                end
                if (idx_q < L1_BIAS) begin
                    Pix_addr = 10'(idx_q);
                end
                if (idx_q == '0) begin
                    acc_d = '0;
                end else if (idx_q <= L1_BIAS) begin
                    acc_d = acc_q + l1_term;
                end
                if (idx_q == L1_DRAIN) begin
                    buf_we = 1'b1;
                    idx_d  = '0;
                    if (nrn_q == L1_LAST) begin
                        state_d = L2;
                        nrn_d   = '0;
                    end else begin
                        nrn_d = nrn_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            L2: begin
                Busy = 1'b1;
                if (idx_q <= L2_BIAS) begin
                    W_addr = WA_W'(L2_OFS) + WA_W'(nrn_q) * WA_W'(N_HID + 1) + WA_W'(idx_q);
                end
                if (idx_q < L2_BIAS) begin
                    buf_raddr = HW'(idx_q);
                end
                if (idx_q == '0) begin
                    acc_d = '0;
                end else if (idx_q <= L2_BIAS) begin
                    acc_d = acc_q + l2_term;
                end
                if (idx_q == L2_DRAIN) begin
                    idx_d = '0;
                    if (win_upd) begin
                        best_d = sum_bias;
                        cand_d = 4'(nrn_q);
                    end
                    if (nrn_q == L2_LAST) begin
                        // Final compare result goes straight to Digit so it
                        // is valid in the Done cycle itself.
                        state_d = FIN;
                        nrn_d   = '0;
                        digit_d = win_upd ? 4'(nrn_q) : cand_q;
`ifdef NN_SCORE_OUT_EN
                        score_d = win_upd ? sum_bias : best_q;
`endif
                    end else begin
                        nrn_d = nrn_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            // FIN is the Done cycle; it is idle from the outside, so a Start
            // here begins the next inference just as from IDLE.
            FIN: begin
                Done = 1'b1;
                if (Start) begin
                    state_d = L1;
                    idx_d   = '0;
                    nrn_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nrn_q   <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            cand_q  <= '0;
            digit_q <= '0;
`ifdef NN_SCORE_OUT_EN
            score_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nrn_q   <= nrn_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            cand_q  <= cand_d;
            digit_q <= digit_d;
`ifdef NN_SCORE_OUT_EN
            score_q <= score_d;
`endif
        end
    end

    assign Digit = digit_q;
`ifdef NN_SCORE_OUT_EN
    assign Max_score = score_q;
`endif

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb_nn_infer_ctrl: directed bench for nn_infer_ctrl with behavioural ROM and
// canvas models (1-cycle read latency). Honors NN_SCORE_OUT_EN for Max_score.
module tb_nn_infer_ctrl;
    import nn_pkg::*;

    localparam int DONE_N     = 1 + DEF_N_HID * (DEF_N_IN + 2) + DEF_N_OUT * (DEF_N_HID + 2);
    localparam int DONE_LIMIT = 26000;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic                    Start;
    logic                    Busy;
    logic                    Done;
    logic [3:0]              Digit;
    logic [9:0]              Pix_addr;
    logic                    Pix_data;
    logic [ROM_AW-1:0]       W_addr;
    logic signed [7:0]       W_data;
`ifdef NN_SCORE_OUT_EN
    logic signed [23:0]      Max_score;
`endif

    int checks   = 0;
    int failures = 0;

    logic signed [7:0] rom [ROM_DEPTH];
    logic              canvas [DEF_N_IN];

    nn_infer_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .Digit     (Digit),
        .Pix_addr  (Pix_addr),
        .Pix_data  (Pix_data),
        .W_addr    (W_addr),
`ifdef NN_SCORE_OUT_EN
        .Max_score (Max_score),
`endif
        .W_data    (W_data)
    );

    always #10 Clk = ~Clk;

    // ROM and canvas: data valid one cycle after the address.
    always @(posedge Clk) begin
        W_data   <= rom[W_addr];
        Pix_data <= canvas[Pix_addr];
    end

    task automatic clear_mem;
        for (int i = 0; i < int'(ROM_DEPTH); i++) rom[i] = 8'sd0;
        for (int i = 0; i < DEF_N_IN; i++) canvas[i] = 1'b0;
    endtask

    function automatic int l1a(input int h, input int i);
        return h * (DEF_N_IN + 1) + i;
    endfunction

    function automatic int l2a(input int o, input int j);
        return int'(L2_BASE) + o * (DEF_N_HID + 1) + j;
    endfunction

    // Logits: o7=5, o8=5 (tie, later index loses), o9=4.
    task automatic load_bias_argmax;
        clear_mem();
        rom[l2a(7, DEF_N_HID)] = 8'sd5;
        rom[l2a(8, DEF_N_HID)] = 8'sd5;
        rom[l2a(9, DEF_N_HID)] = 8'sd4;
    endtask

    // Pixels 0..199 set. hid0=127>>6=1, hid1=clamp(-100>>6)=0,
    // hid2=clamp(25400>>6=396)=255, hid3=0 (weight on an unset pixel).
    // Logits: o1=50*0=0, o2=1, o3=127, o4=255+100*1-128=227, o5=127*0=0.
    task automatic load_relu_mac;
        clear_mem();
        for (int i = 0; i < 200; i++) canvas[i] = 1'b1;
        rom[l1a(0, 0)]        = 8'sd127;
        rom[l1a(1, DEF_N_IN)] = -8'sd100;
        for (int i = 0; i < 200; i++) rom[l1a(2, i)] = 8'sd127;
        rom[l1a(3, 300)]      = 8'sd127;
        rom[l2a(1, 1)]        = 8'sd50;
        rom[l2a(2, DEF_N_HID)] = 8'sd1;
        rom[l2a(3, DEF_N_HID)] = 8'sd127;
        rom[l2a(4, 2)]        = 8'sd1;
        rom[l2a(4, 0)]        = 8'sd100;
        rom[l2a(4, DEF_N_HID)] = -8'sd128;
        rom[l2a(5, 3)]        = 8'sd127;
    endtask

    // Bounded wait; n is the cycle index after the Start edge (1 = first
    // busy cycle), or -1 if Done never came.
    task automatic wait_done(output int n, output int busy_cnt);
        n = 1;
        busy_cnt = 0;
        while (Done !== 1'b1 && n <= DONE_LIMIT) begin
            if (Busy === 1'b1) busy_cnt++;
            @(negedge Clk);
            n++;
        end
        if (Done !== 1'b1) n = -1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Start = 1'b0;
        clear_mem();
        repeat (3) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", Done); end
        checks++; if (Digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", Digit); end
        checks++; if (Pix_addr !== 10'd0) begin failures++; $display("FAIL reset_pix_addr got=%0d exp=0", Pix_addr); end
        checks++; if (W_addr !== '0) begin failures++; $display("FAIL reset_w_addr got=%0d exp=0", W_addr); end
`ifdef NN_SCORE_OUT_EN
        checks++; if (Max_score !== 24'sd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", Max_score); end
`endif
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // All-zero ROM, extra Start pulse mid-L1, address sequencing and timing.
    task automatic test_zero_weights;
        int n;
        int busy_cnt;
        clear_mem();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (Done !== 1'b1 && n <= DONE_LIMIT) begin
            if (Busy === 1'b1) busy_cnt++;
            Start = (n == 1000);
            case (n)
                1: begin
                    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%0b exp=1", Busy); end
                    checks++; if (W_addr !== 15'd0) begin failures++; $display("FAIL w_addr_n1 got=%0d exp=0", W_addr); end
                end
                2: begin
                    checks++; if (W_addr !== 15'd1) begin failures++; $display("FAIL w_addr_n2 got=%0d exp=1", W_addr); end
                    checks++; if (Pix_addr !== 10'd1) begin failures++; $display("FAIL pix_addr_n2 got=%0d exp=1", Pix_addr); end
                end
                785: begin
                    checks++; if (W_addr !== 15'd784) begin failures++; $display("FAIL w_addr_bias got=%0d exp=784", W_addr); end
                    checks++; if (Pix_addr !== 10'd0) begin failures++; $display("FAIL pix_addr_bias got=%0d exp=0", Pix_addr); end
                end
                788: begin
                    checks++; if (W_addr !== 15'd786) begin failures++; $display("FAIL w_addr_h1 got=%0d exp=786", W_addr); end
                    checks++; if (Pix_addr !== 10'd1) begin failures++; $display("FAIL pix_addr_h1 got=%0d exp=1", Pix_addr); end
                end
                25153: begin
                    checks++; if (W_addr !== 15'd25120) begin failures++; $display("FAIL w_addr_l2 got=%0d exp=25120", W_addr); end
                    checks++; if (Pix_addr !== 10'd0) begin failures++; $display("FAIL pix_addr_l2 got=%0d exp=0", Pix_addr); end
                end
                default: ;
            endcase
            @(negedge Clk);
            n++;
        end
        Start = 1'b0;
        if (Done !== 1'b1) n = -1;
        checks++; if (n != 25493) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=25493", n); end
        checks++; if (busy_cnt != 25492) begin failures++; $display("FAIL zero_busy_len got=%0d exp=25492", busy_cnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL zero_busy_at_done got=%0b exp=0", Busy); end
        checks++; if (Digit !== 4'd0) begin failures++; $display("FAIL zero_digit got=%0d exp=0", Digit); end
`ifdef NN_SCORE_OUT_EN
        checks++; if (Max_score !== 24'sd0) begin failures++; $display("FAIL zero_score got=%0d exp=0", Max_score); end
`endif
        @(negedge Clk);
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%0b exp=0", Done); end
        checks++; if (Digit !== 4'd0) begin failures++; $display("FAIL zero_digit_hold got=%0d exp=0", Digit); end
    endtask

    // Ends sampling in the Done cycle so the next inference starts back to back.
    task automatic test_bias_argmax;
        int n;
        int busy_cnt;
        load_bias_argmax();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n, busy_cnt);
        checks++; if (n != DONE_N) begin failures++; $display("FAIL bias_done_cycle got=%0d exp=%0d", n, DONE_N); end
        checks++; if (Digit !== 4'd7) begin failures++; $display("FAIL bias_digit got=%0d exp=7", Digit); end
`ifdef NN_SCORE_OUT_EN
        checks++; if (Max_score !== 24'sd5) begin failures++; $display("FAIL bias_score got=%0d exp=5", Max_score); end
`endif
    endtask

    // Start in the Done cycle; 25492 cycles lie strictly between the pulses.
    task automatic test_back_to_back;
        int n;
        int busy_cnt;
        Start = 1'b1;
        load_relu_mac();
        @(negedge Clk);
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", Busy); end
        wait_done(n, busy_cnt);
        checks++; if (n - 1 != 25492) begin failures++; $display("FAIL b2b_gap got=%0d exp=25492", n - 1); end
        checks++; if (Digit !== 4'd4) begin failures++; $display("FAIL relu_mac_digit got=%0d exp=4", Digit); end
`ifdef NN_SCORE_OUT_EN
        checks++; if (Max_score !== 24'sd227) begin failures++; $display("FAIL relu_mac_score got=%0d exp=227", Max_score); end
`endif
        @(negedge Clk);
        checks++; if (Digit !== 4'd4) begin failures++; $display("FAIL relu_mac_hold got=%0d exp=4", Digit); end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (200) @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%0b exp=1", Busy); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", Done); end
        checks++; if (Digit !== 4'd0) begin failures++; $display("FAIL abort_digit got=%0d exp=0", Digit); end
        checks++; if (W_addr !== '0) begin failures++; $display("FAIL abort_w_addr got=%0d exp=0", W_addr); end
        checks++; if (Pix_addr !== 10'd0) begin failures++; $display("FAIL abort_pix_addr got=%0d exp=0", Pix_addr); end
        Reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        @(negedge Clk);
        test_reset();
        test_zero_weights();
        test_bias_argmax();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
